pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 16-bit SIMPLE core.
- Sits between IF/ID and ID/EX and watches the decode-stage command (id_cmd) and the execute-stage command (ex_cmd).
- Detects load-use hazards internally (superset of the combinational stall judgement) and turns them, plus branch redirects and HLT, into multi-cycle control.
- Drives PC write-enable, IF/ID enable/flush and ID/EX bubble insertion through a small FSM.

Parameters:
- STALL_CYCLES, 1, load-use penalty in cycles (1..7); bubble held this many cycles.
- NOP_CMD, 16'b11_000_000_1011_0000, value the ID/EX register loads on bubble (taken from idex_nop output).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_cmd  in  16  command in decode stage
- ex_cmd  in  16  command in execute stage
- ex_valid  in  1  ex_cmd is a real instruction (0 = bubble)
- branch_taken  in  1  EX resolved a taken branch this cycle
- resume  in  1  one-cycle pulse leaving HALT
- pc_we  out  1  PC register update enable
- ifid_we  out  1  IF/ID register update enable
- ifid_flush  out  1  IF/ID loads NOP_CMD
- idex_bubble  out  1  ID/EX loads NOP_CMD instead of decoded id_cmd
- idex_nop  out  16  constant NOP_CMD
- halted  out  1  FSM in HALT
- state  out  2  00 RUN, 01 STALL, 10 HALT, 11 reserved (never entered)

Behaviour:
- Field decode: op=[15:14], ra=[13:11], rb=[10:8], op3=[7:4].
- Load: ex_cmd op==00.
- id_cmd reads:
  - op==11: ra and rb, except op3==1111 (HLT) and op3==1011 (NOP), which read nothing.
  - op==00 (LD): rb.
  - op==01 (ST): ra and rb.
  - op==10 (branch group): rb.
- hazard = ex_valid & load & id reads ex_cmd[13:11].
- FSM state and 3-bit stall counter are registered; all outputs are combinational from state, counter and inputs (zero-latency response).
- Reset (rst==1 at edge): state<=RUN, counter<=0.
  - While rst is high, outputs are pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, halted=0.
- RUN:
  - Default: pc_we=ifid_we=1, ifid_flush=idex_bubble=0.
  - Priority 1, branch_taken: pc_we=1, ifid_flush=1, idex_bubble=1; stay in RUN. Branch overrides hazard and HLT because id_cmd is on the wrong path.
  - Priority 2, id_cmd is HLT: pc_we=0, ifid_we=0, idex_bubble=0 (HLT itself proceeds). Next state HALT.
  - Priority 3, hazard: pc_we=0, ifid_we=0, idex_bubble=1.
    - If STALL_CYCLES>1: next state STALL, counter<=STALL_CYCLES-1.
    - Else stay in RUN.
- STALL:
  - pc_we=0, ifid_we=0, idex_bubble=1; counter decrements each cycle.
  - Leave to RUN on the cycle counter==1 (after the decrement it is 0).
  - branch_taken in STALL cannot occur, because EX holds a bubble. If asserted anyway, treat as in RUN: flush and go to RUN, counter<=0.
- HALT:
  - pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, halted=1.
  - resume: next state RUN, and the cycle after resume acts as RUN.
  - resume outside HALT is ignored.
- STALL_CYCLES==0 is illegal; the bench checks only 1..7.

Optional Feature:
- Macro HAZARD_PERF_COUNTERS_EN.
- When defined, two extra outputs:
  - stall_count[15:0]: counts cycles with idex_bubble=1 caused by hazard/STALL.
  - flush_count[15:0]: counts branch flushes.
- Both counters saturate at 16'hFFFF (no wrap), clear on rst, and exclude HALT cycles.
- When undefined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset: hold rst 2 cycles, release -> state=00 after release; while rst high pc_we=0, idex_bubble=1, ifid_flush=1.
- Load-use, STALL_CYCLES=1: ex_cmd=00_111_101_00000000 (LD r7), ex_valid=1, id_cmd=11_111_001_00000000 -> pc_we=0, ifid_we=0, idex_bubble=1 for exactly 1 cycle, state stays 00. Same id_cmd with ex_cmd=11_101_111_0010_0000 -> no stall.
- Non-reading command: id_cmd=11_111_000_1011_0000 (NOP) after LD r7 -> no stall. id_cmd=01_000_111_00000000 (ST reading r7) -> stall.
- STALL_CYCLES=3: LD r5 then id_cmd reading rb=101 -> bubble 3 consecutive cycles; state 00,01,01 then 00; pc_we resumes on cycle 4.
- Branch priority: branch_taken=1 in the same cycle as a hazard and HLT in id -> ifid_flush=1, idex_bubble=1, pc_we=1, state stays 00; with the macro on, flush_count +1 and stall_count unchanged.
- HALT: id_cmd=11_000_000_1111_0000 -> next cycle halted=1, state=10, pc_we=0 for 5 cycles; resume pulse -> state=00 next cycle. rst asserted mid-HALT -> state=00 after the edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 16-bit SIMPLE core: load-use stalls, branch flushes, HLT/resume.
// Optional HAZARD_PERF_COUNTERS_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int          STALL_CYCLES = 1,
  parameter logic [15:0] NOP_CMD      = 16'b11_000_000_1011_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_cmd,
  input  logic [15:0] ex_cmd,
  input  logic        ex_valid,
  input  logic        branch_taken,
  input  logic        resume,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [15:0] idex_nop,
  output logic        halted,
  output logic [1:0]  state
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_STALL = 2'b01;
  localparam logic [1:0] S_HALT  = 2'b10;
  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       hazard;
  logic       stall_ev;
  logic       flush_ev;
  logic       unused_bits;

  function automatic logic is_load(input logic [15:0] cmd);
    return cmd[15:14] == 2'b00;
  endfunction

  function automatic logic is_hlt(input logic [15:0] cmd);
    return (cmd[15:14] == 2'b11) && (cmd[7:4] == 4'b1111);
  endfunction

  // Which source registers a decode-stage command actually reads.
  function automatic logic reads_reg(input logic [15:0] cmd, input logic [2:0] r);
    logic rd_ra;
    logic rd_rb;
    rd_ra = 1'b0;
    rd_rb = 1'b0;
    case (cmd[15:14])
      2'b11: begin
        if (cmd[7:4] != 4'b1111 && cmd[7:4] != 4'b1011) begin
          rd_ra = 1'b1;
          rd_rb = 1'b1;
        end
      end
      2'b00: rd_rb = 1'b1;
      2'b01: begin
        rd_ra = 1'b1;
        rd_rb = 1'b1;
      end
      default: rd_rb = 1'b1;
    endcase
    return (rd_ra && cmd[13:11] == r) || (rd_rb && cmd[10:8] == r);
  endfunction

  assign unused_bits = ^{id_cmd[3:0], ex_cmd[10:0]};
  assign hazard      = ex_valid && is_load(ex_cmd) && reads_reg(id_cmd, ex_cmd[13:11]);
  assign idex_nop    = NOP_CMD;
  assign state       = state_q;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    case (state_q)
      S_RUN: begin
        // A taken branch means id_cmd is on the wrong path, so it outranks HLT and hazards.
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_ev    = 1'b1;
          cnt_d       = 3'd0;
        end else if (is_hlt(id_cmd)) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          state_d = S_HALT;
        end else if (hazard) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          stall_ev    = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = S_STALL;
            cnt_d   = STALL_INIT;
          end
        end
      end
      S_STALL: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_ev    = 1'b1;
          state_d     = S_RUN;
          cnt_d       = 3'd0;
        end else begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          stall_ev    = 1'b1;
          cnt_d       = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          if (cnt_q <= 3'd1) state_d = S_RUN;
        end
      end
      S_HALT: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        halted      = 1'b1;
        if (resume) state_d = S_RUN;
      end
      default: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
        state_d     = S_RUN;
        cnt_d       = 3'd0;
      end
    endcase
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      halted      = 1'b0;
      stall_ev    = 1'b0;
      flush_ev    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_COUNTERS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (stall_ev) stall_count <= sat_inc(stall_count);
      if (flush_ev) flush_count <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: one instance with STALL_CYCLES=1, one with STALL_CYCLES=3.
module tb_pipeline_hazard_ctrl;

  // Expected encoding: {state[1:0], pc_we, ifid_we, ifid_flush, idex_bubble, halted}
  localparam logic [6:0] E_RST  = 7'b00_00110;
  localparam logic [6:0] E_RUN  = 7'b00_11000;
  localparam logic [6:0] E_HZ0  = 7'b00_00010;
  localparam logic [6:0] E_ST1  = 7'b01_00010;
  localparam logic [6:0] E_BR0  = 7'b00_11110;
  localparam logic [6:0] E_BR1  = 7'b01_11110;
  localparam logic [6:0] E_HL0  = 7'b00_00000;
  localparam logic [6:0] E_HALT = 7'b10_00011;

  localparam logic [15:0] NOP    = 16'b11_000_000_1011_0000;
  localparam logic [15:0] HLT    = 16'b11_000_000_1111_0000;
  localparam logic [15:0] LD7    = 16'b00_111_101_0000_0000;
  localparam logic [15:0] LD5    = 16'b00_101_000_0000_0000;
  localparam logic [15:0] ID_RA7 = 16'b11_111_001_0000_0000;
  localparam logic [15:0] ALU_EX = 16'b11_101_111_0010_0000;
  localparam logic [15:0] NOP_R7 = 16'b11_111_000_1011_0000;
  localparam logic [15:0] ST7    = 16'b01_000_111_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_cmd, ex_cmd;
  logic        ex_valid, branch_taken, resume;
  logic        pc1, we1, fl1, bb1, h1, pc3, we3, fl3, bb3, h3;
  logic [15:0] nop1, nop3;
  logic [1:0]  st1, st3;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [15:0] sc1, fc1, sc3, fc3;
  logic [15:0] esc1 = 16'd0, efc1 = 16'd0, esc3 = 16'd0, efc3 = 16'd0;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [14:0] sb_q[$];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.STALL_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .id_cmd(id_cmd), .ex_cmd(ex_cmd), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .resume(resume), .pc_we(pc1), .ifid_we(we1),
    .ifid_flush(fl1), .idex_bubble(bb1), .idex_nop(nop1), .halted(h1), .state(st1)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_count(sc1), .flush_count(fc1)
`endif
  );

  pipeline_hazard_ctrl #(.STALL_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .id_cmd(id_cmd), .ex_cmd(ex_cmd), .ex_valid(ex_valid),
    .branch_taken(branch_taken), .resume(resume), .pc_we(pc3), .ifid_we(we3),
    .ifid_flush(fl3), .idex_bubble(bb3), .idex_nop(nop3), .halted(h3), .state(st3)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic r, input logic [15:0] id, input logic [15:0] ex,
                       input logic exv, input logic br, input logic res,
                       input logic [6:0] e1, input logic [6:0] e3);
    logic [14:0] ent;
    logic [6:0]  x1, x3;
    logic        xr;
    rst = r; id_cmd = id; ex_cmd = ex; ex_valid = exv; branch_taken = br; resume = res;
    sb_q.push_back({r, e1, e3});
    @(negedge clk);
    ent = sb_q.pop_front();
    xr = ent[14]; x1 = ent[13:7]; x3 = ent[6:0];
    check({tag, "/out1"}, {27'd0, pc1, we1, fl1, bb1, h1}, {27'd0, x1[4:0]});
    check({tag, "/out3"}, {27'd0, pc3, we3, fl3, bb3, h3}, {27'd0, x3[4:0]});
    if (!xr) begin
      check({tag, "/state1"}, {30'd0, st1}, {30'd0, x1[6:5]});
      check({tag, "/state3"}, {30'd0, st3}, {30'd0, x3[6:5]});
    end
`ifdef HAZARD_PERF_COUNTERS_EN
    check({tag, "/stall_cnt1"}, {16'd0, sc1}, {16'd0, esc1});
    check({tag, "/flush_cnt1"}, {16'd0, fc1}, {16'd0, efc1});
    check({tag, "/stall_cnt3"}, {16'd0, sc3}, {16'd0, esc3});
    check({tag, "/flush_cnt3"}, {16'd0, fc3}, {16'd0, efc3});
    if (xr) begin
      esc1 = 16'd0; efc1 = 16'd0; esc3 = 16'd0; efc3 = 16'd0;
    end else begin
      if (x1[1] && !x1[2] && !x1[0]) esc1 = esc1 + 16'd1;
      if (x1[2]) efc1 = efc1 + 16'd1;
      if (x3[1] && !x3[2] && !x3[0]) esc3 = esc3 + 16'd1;
      if (x3[2]) efc3 = efc3 + 16'd1;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  // Hazard cycle, then the bubble reaches EX (ex_valid low) for three cycles.
  task automatic loaduse(input string tag, input logic [15:0] id, input logic [15:0] ex);
    apply({tag, "_c0"}, 1'b0, id, ex, 1'b1, 1'b0, 1'b0, E_HZ0, E_HZ0);
    apply({tag, "_c1"}, 1'b0, id, ex, 1'b0, 1'b0, 1'b0, E_RUN, E_ST1);
    apply({tag, "_c2"}, 1'b0, id, ex, 1'b0, 1'b0, 1'b0, E_RUN, E_ST1);
    apply({tag, "_c3"}, 1'b0, id, ex, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);
  endtask

  task automatic nostall(input string tag, input logic [15:0] id, input logic [15:0] ex, input logic exv);
    apply(tag, 1'b0, id, ex, exv, 1'b0, 1'b0, E_RUN, E_RUN);
  endtask

  initial begin
    rst = 1'b1; id_cmd = NOP; ex_cmd = NOP; ex_valid = 1'b0; branch_taken = 1'b0; resume = 1'b0;
    #1;
    apply("rst0", 1'b1, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
    apply("rst1", 1'b1, HLT, LD7, 1'b1, 1'b1, 1'b0, E_RST, E_RST);
    apply("idle", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);
    check("nop_cmd1", {16'd0, nop1}, 32'h0000_C0B0);
    check("nop_cmd3", {16'd0, nop3}, 32'h0000_C0B0);

    loaduse("ld7_ra", ID_RA7, LD7);
    nostall("alu_ex", ID_RA7, ALU_EX, 1'b1);
    nostall("ld_invalid", ID_RA7, LD7, 1'b0);
    nostall("nop_id", NOP_R7, LD7, 1'b1);
    loaduse("st_rb", ST7, LD7);
    loaduse("ld5_rb", 16'b11_000_101_0000_0000, LD5);
    nostall("ld_ra_only", 16'b00_101_000_0000_0000, LD5, 1'b1);
    loaduse("br_rb", 16'b10_000_101_0000_0000, LD5);

    apply("br_hz", 1'b0, ID_RA7, LD7, 1'b1, 1'b1, 1'b0, E_BR0, E_BR0);
    apply("br_hlt", 1'b0, HLT, LD7, 1'b1, 1'b1, 1'b0, E_BR0, E_BR0);
    apply("post_br", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);

    apply("hz_pre_br", 1'b0, ID_RA7, LD7, 1'b1, 1'b0, 1'b0, E_HZ0, E_HZ0);
    apply("br_stall", 1'b0, ID_RA7, LD7, 1'b0, 1'b1, 1'b0, E_BR0, E_BR1);
    apply("post_br2", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);

    apply("res_run", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, E_RUN, E_RUN);
    apply("hlt_id", 1'b0, HLT, NOP, 1'b0, 1'b0, 1'b0, E_HL0, E_HL0);
    for (int i = 0; i < 5; i++)
      apply("halt", 1'b0, HLT, LD7, 1'b1, 1'b0, 1'b0, E_HALT, E_HALT);
    apply("resume", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b1, E_HALT, E_HALT);
    apply("after_res", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);

    apply("hlt_id2", 1'b0, HLT, NOP, 1'b0, 1'b0, 1'b0, E_HL0, E_HL0);
    apply("halt2", 1'b0, HLT, NOP, 1'b0, 1'b0, 1'b0, E_HALT, E_HALT);
    apply("rst_halt", 1'b1, HLT, NOP, 1'b0, 1'b0, 1'b0, E_RST, E_RST);
    apply("post_rst", 1'b0, NOP, NOP, 1'b0, 1'b0, 1'b0, E_RUN, E_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
